encoder_32: RTL and testbench
=============================

# encoder_32

Registered 32-to-5 priority encoder with request latching and a valid/ready output handshake. It is the inverse of the 5-to-32 one-hot decoder used for register-write selection: it collapses 32 request lines (interrupt causes, scoreboard ready bits) into one 5-bit index per transfer. Requests are held as sticky pending bits until they are claimed. Sits between the request sources and the processor control logic that consumes one index per cycle.

## Interface
- No parameters. Width is fixed at 32 requests and a 5-bit index.
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- req_in  input  32  request bits; a bit high at a rising edge sets the matching pending bit.
- mask  input  32  per-bit enable; only bits with pending & mask are eligible for a claim.
- clr_all  input  1  synchronous flush of all pending bits and of the output stage.
- out_ready  input  1  consumer accepts out_idx this cycle.
- out_valid  output  1  out_idx holds a claimed request.
- out_idx  output  5  encoded index of the claimed request.
- pending  output  32  current pending register.
- busy  output  1  high when pending is nonzero or out_valid is high (combinational).

## Operation
- Pending register, next value:
  - clr_all=1: 0.
  - Otherwise: (pending & ~claim_onehot) | req_in.
  - If a bit is set by req_in on the same edge its claim clears it, set wins and the bit stays pending.
- Output stage can load when out_valid=0, or when out_valid=1 and out_ready=1.
- Load rule:
  - eligible = pending & mask, using the registered pending value only. The current cycle's req_in is not included.
  - Nonzero eligible: out_valid←1, out_idx←selected index, and that index's pending bit is cleared on the same edge (the claim).
  - Zero eligible: out_valid←0 and out_idx holds its value.
- While out_valid=1 and out_ready=0, out_idx and out_valid hold and nothing is claimed.
- Default selection is fixed priority: the lowest eligible index wins (bit 0 highest).
- clr_all overrides everything else:
  - out_valid←0 and pending←0 on the next edge.
  - No claim occurs that cycle, and that cycle's req_in is discarded.
- A mask change affects only future claims. An index already in the output stage is still delivered.
- An index is never lost and never duplicated. Each pending set produces exactly one transfer unless clr_all flushes it.

## Timing
- Reset (reset_n=0, asynchronous): pending=0, out_valid=0, out_idx=0, busy=0, round-robin pointer=31.
- Latency: req_in bit high at edge N gives pending at N and out_valid with out_idx at edge N+1, provided the output stage is free and the bit is masked in.
- Throughput: one index per cycle while out_ready=1 and eligible is nonzero.
- Transfer completes on the edge where out_valid=1 and out_ready=1. A new index can be presented on that same edge (back-to-back).
- Reset deasserted mid-stream: all state is restarted from reset values, with no partial transfer.

## Configuration
- Macro ENCODER_ROUND_ROBIN_EN.
- Defined: round-robin selection.
  - A 5-bit pointer holds the last claimed index.
  - The search starts at pointer+1 and wraps 31→0; the first eligible bit found wins.
  - The pointer updates to the claimed index on each claim.
  - The pointer resets to 31, so the first search starts at bit 0.
  - clr_all does not change the pointer.
- Undefined: fixed lowest-index priority and no pointer register. Interface is identical in both builds.

## Test plan
- Reset with reset_n=0: pending=0, out_valid=0, out_idx=0, busy=0. Release reset with all inputs 0: outputs stay idle.
- Fixed priority: req_in=32'h8000_0014 for one cycle, mask=all ones, out_ready=1.
  - out_idx sequence 2, 4, 31 on consecutive cycles, then out_valid=0.
  - pending ends at 0.
- Backpressure: pulse bit 5 and bit 9 with out_ready=0.
  - out_idx=5 holds for 4 cycles with pending=32'h200.
  - Raise out_ready: 5 transfers, then 9 on the next cycle.
- Set/claim collision: bit 3 pending and being claimed while req_in[3]=1 on the same edge.
  - out_idx=3 is delivered and pending[3] stays 1.
  - A second out_idx=3 follows.
- Mask and flush:
  - pending=32'hF0 with mask=32'h0F: out_valid stays 0.
  - Set mask=all ones: out_idx=4.
  - Assert clr_all while out_valid=1: out_valid=0 and pending=0 next edge.
- ENCODER_ROUND_ROBIN_EN build: hold req_in bits 1 and 2 high continuously, out_ready=1.
  - out_idx alternates 1, 2, 1, 2.
  - Without the macro, out_idx=1 every cycle.

Source files
------------

// File: rtl/encoder_32.sv
// encoder_32: registered 32-to-5 priority encoder with sticky pending bits
// and a valid/ready output stage.
// Build option: define ENCODER_ROUND_ROBIN_EN for round-robin selection
// (default build uses fixed lowest-index priority).
module encoder_32 (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] req_in,
  input  logic [31:0] mask,
  input  logic        clr_all,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [4:0]  out_idx,
  output logic [31:0] pending,
  output logic        busy
);

  localparam int unsigned NReq = 32;
  localparam int unsigned IdxW = 5;

  logic [NReq-1:0] pending_q, pending_d;
  logic            out_valid_q, out_valid_d;
  logic [IdxW-1:0] out_idx_q, out_idx_d;

  logic [NReq-1:0] eligible;
  logic [NReq-1:0] claim_onehot;
  logic [IdxW-1:0] sel_idx;
  logic            sel_found;
  logic            can_load;
  logic            claim;

  assign eligible = pending_q & mask;
  assign can_load = !out_valid_q || out_ready;
  assign claim    = !clr_all && can_load && sel_found;

`ifdef ENCODER_ROUND_ROBIN_EN
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] cand;

  // Search upward from the slot after the last claim, wrapping 31 -> 0.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 0; i < int'(NReq); i++) begin
      cand = ptr_q + IdxW'(i) + IdxW'(1);
      if (!sel_found && eligible[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Pointer remembers the last claimed index; flush leaves it alone.
  always_comb begin
    ptr_d = ptr_q;
    if (claim) ptr_d = sel_idx;
  end

  // Pointer register; reset value makes the first search start at bit 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ptr_q <= '1;
    else          ptr_q <= ptr_d;
  end
`else
  // Fixed priority: scan high to low so the lowest eligible bit is kept.
  always_comb begin
    sel_found = |eligible;
    sel_idx   = '0;
    for (int i = int'(NReq) - 1; i >= 0; i--) begin
      if (eligible[i]) sel_idx = IdxW'(i);
    end
  end
`endif

  // Next-state for pending bits and the output stage.
  always_comb begin
    claim_onehot = '0;
    pending_d    = pending_q;
    out_valid_d  = out_valid_q;
    out_idx_d    = out_idx_q;
    if (claim) claim_onehot = NReq'(1) << sel_idx;
    if (clr_all) begin
      pending_d   = '0;
      out_valid_d = 1'b0;
    end else begin
      // A new request on the claim edge wins over the claim.
      pending_d = (pending_q & ~claim_onehot) | req_in;
      if (can_load) begin
        out_valid_d = sel_found;
        if (sel_found) out_idx_d = sel_idx;
      end
    end
  end

  // State registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
    end else begin
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign pending   = pending_q;
  assign busy      = (|pending_q) || out_valid_q;

endmodule

// File: tb/tb_encoder_32.sv
// Self-checking bench for encoder_32: directed scenarios plus randomized
// traffic compared against a transfer-level reference model.
module tb_encoder_32;

  logic        clock;
  logic        reset_n;
  logic [31:0] req_in;
  logic [31:0] mask;
  logic        clr_all;
  logic        out_ready;
  logic        out_valid;
  logic [4:0]  out_idx;
  logic [31:0] pending;
  logic        busy;

  int n_cmp;
  int n_bad;

  // Reference state
  bit [31:0] m_pend;
  bit        m_valid;
  int        m_idx;
  int        m_ptr;

  encoder_32 dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_in    (req_in),
    .mask      (mask),
    .clr_all   (clr_all),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .pending   (pending),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pend  = '0;
    m_valid = 1'b0;
    m_idx   = 0;
    m_ptr   = 31;
  endtask

  // Choose which eligible request is granted next.
  function automatic int pick(input bit [31:0] elig, input int ptr);
`ifdef ENCODER_ROUND_ROBIN_EN
    for (int s = 1; s <= 32; s++) begin
      if (elig[(ptr + s) % 32]) return (ptr + s) % 32;
    end
`else
    for (int k = 0; k < 32; k++) begin
      if (elig[k]) return k;
    end
`endif
    return -1;
  endfunction

  // One clock edge of the reference: grant, consume, then record new requests.
  task automatic model_edge(input bit [31:0] req, input bit [31:0] msk,
                            input bit clr, input bit rdy);
    int k;
    if (clr) begin
      m_pend  = '0;
      m_valid = 1'b0;
      return;
    end
    if (!m_valid || rdy) begin
      k = pick(m_pend & msk, m_ptr);
      if (k >= 0) begin
        m_valid   = 1'b1;
        m_idx     = k;
        m_pend[k] = 1'b0;
        m_ptr     = k;
      end else begin
        m_valid = 1'b0;
      end
    end
    m_pend = m_pend | req;
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
    check({tag, ".idx"}, 32'(out_idx), 32'(m_idx));
    check({tag, ".pend"}, pending, m_pend);
    check({tag, ".busy"}, 32'(busy), 32'((m_pend != 0) || m_valid));
  endtask

  // Apply inputs for one edge, advance model, compare on the falling edge.
  task automatic step(input logic [31:0] req, input logic [31:0] msk,
                      input logic clr, input logic rdy, input string tag);
    req_in    = req;
    mask      = msk;
    clr_all   = clr;
    out_ready = rdy;
    @(posedge clock);
    model_edge(req, msk, clr, rdy);
    @(negedge clock);
    compare_model(tag);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    model_reset();
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.idx", 32'(out_idx), 32'd0);
    check("rst.pend", pending, 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    reset_n   = 1'b0;
    req_in    = '0;
    mask      = '0;
    clr_all   = 1'b0;
    out_ready = 1'b0;
    model_reset();
    #3;
    do_reset();

    // Idle after reset
    for (int i = 0; i < 3; i++) step(32'h0, 32'h0, 1'b0, 1'b0, "idle");
    check("idle.valid", 32'(out_valid), 32'd0);

    // Fixed-priority drain of three requests
    step(32'h8000_0014, '1, 1'b0, 1'b1, "fp.set");
    step(32'h0, '1, 1'b0, 1'b1, "fp.c1");
    check("fp.idx2", 32'(out_idx), 32'd2);
    step(32'h0, '1, 1'b0, 1'b1, "fp.c2");
    check("fp.idx4", 32'(out_idx), 32'd4);
    step(32'h0, '1, 1'b0, 1'b1, "fp.c3");
    check("fp.idx31", 32'(out_idx), 32'd31);
    check("fp.v31", 32'(out_valid), 32'd1);
    step(32'h0, '1, 1'b0, 1'b1, "fp.c4");
    check("fp.done", 32'(out_valid), 32'd0);
    check("fp.pend0", pending, 32'd0);

    // Backpressure holds the output stage
    step(32'h0000_0220, '1, 1'b0, 1'b0, "bp.set");
    step(32'h0, '1, 1'b0, 1'b0, "bp.load");
    for (int i = 0; i < 4; i++) begin
      step(32'h0, '1, 1'b0, 1'b0, "bp.hold");
      check("bp.idx5", 32'(out_idx), 32'd5);
      check("bp.pend", pending, 32'h200);
    end
    step(32'h0, '1, 1'b0, 1'b1, "bp.x5");
    check("bp.idx9", 32'(out_idx), 32'd9);
    check("bp.v9", 32'(out_valid), 32'd1);
    step(32'h0, '1, 1'b0, 1'b1, "bp.x9");
    check("bp.done", 32'(out_valid), 32'd0);

    // Set and claim of bit 3 on the same edge
    step(32'h8, '1, 1'b0, 1'b1, "col.set");
    step(32'h8, '1, 1'b0, 1'b1, "col.hit");
    check("col.idx3a", 32'(out_idx), 32'd3);
    check("col.pend3", 32'(pending[3]), 32'd1);
    step(32'h0, '1, 1'b0, 1'b1, "col.again");
    check("col.idx3b", 32'(out_idx), 32'd3);
    check("col.v3b", 32'(out_valid), 32'd1);
    step(32'h0, '1, 1'b0, 1'b1, "col.end");
    check("col.done", 32'(out_valid), 32'd0);

    // Mask gating, then flush while valid
    step(32'hF0, 32'h0F, 1'b0, 1'b0, "mf.set");
    step(32'h0, 32'h0F, 1'b0, 1'b0, "mf.gate");
    check("mf.novalid", 32'(out_valid), 32'd0);
    step(32'h0, '1, 1'b0, 1'b0, "mf.open");
    check("mf.idx4", 32'(out_idx), 32'd4);
    check("mf.v4", 32'(out_valid), 32'd1);
    step(32'h1, '1, 1'b1, 1'b0, "mf.clr");
    check("mf.clrv", 32'(out_valid), 32'd0);
    check("mf.clrp", pending, 32'd0);
    check("mf.busy", 32'(busy), 32'd0);

    // Continuous requests on bits 1 and 2
    do_reset();
    step(32'h6, '1, 1'b0, 1'b1, "rr.set");
    for (int i = 0; i < 4; i++) begin
      step(32'h6, '1, 1'b0, 1'b1, "rr.run");
`ifdef ENCODER_ROUND_ROBIN_EN
      check("rr.alt", 32'(out_idx), (i % 2 == 0) ? 32'd1 : 32'd2);
`else
      check("rr.fixed", 32'(out_idx), 32'd1);
`endif
    end

    // Randomized traffic with occasional flush and mid-stream reset
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] r, m;
      logic        c, y;
      r = ($urandom_range(0, 3) == 0) ? ($urandom() & $urandom()) : 32'h0;
      m = ($urandom_range(0, 3) == 0) ? $urandom() : 32'hFFFF_FFFF;
      c = ($urandom_range(0, 63) == 0);
      y = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      step(r, m, c, y, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
